// File: rtl/ex_div_pkg.sv
// ============================================================================
// ex_div_pkg : shared encodings and widths for the execute-stage divider
// Revision   : 1.0
// ============================================================================
`default_nettype none

package ex_div_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  // OP opcode; divide ops are distinguished by funct7 = 0000001 and funct3
  localparam logic [6:0] OPCODE_M = 7'b0110011;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
    return (~v) + XLEN'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_div_if.sv
// ============================================================================
// ex_div_if : issue / result bundle between ex and the divider
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface ex_div_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               start_i;
  logic [2:0]         funct3_i;
  logic [XLEN-1:0]    dividend_i;
  logic [XLEN-1:0]    divisor_i;
  logic [RADDR_W-1:0] rd_i;
  logic               hold_flag_i;
  logic               busy_o;
  logic               done_o;
  logic [XLEN-1:0]    result_o;
  logic [RADDR_W-1:0] rd_o;
  logic               rd_wr_en_o;

  modport master (
    output start_i, funct3_i, dividend_i, divisor_i, rd_i, hold_flag_i,
    input  busy_o, done_o, result_o, rd_o, rd_wr_en_o
  );

  modport slave (
    input  start_i, funct3_i, dividend_i, divisor_i, rd_i, hold_flag_i,
    output busy_o, done_o, result_o, rd_o, rd_wr_en_o
  );
endinterface

`default_nettype wire

// File: rtl/ex_div.sv
// ============================================================================
// ex_div   : multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_div
  import ex_div_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst_n,
  ex_div_if.slave   bus
);

  localparam int CNT_W = $clog2(XLEN);

  state_e             state_q, state_d;
  logic               op_rem_q, op_rem_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [XLEN-1:0]    dvsr_q, dvsr_d;
  logic [XLEN-1:0]    rem_q, rem_d;
  logic [XLEN-1:0]    quot_q, quot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [RADDR_W-1:0] rd_lat_q, rd_lat_d;
  logic [RADDR_W-1:0] rd_out_q, rd_out_d;

  logic            w_signed_op, w_a_neg, w_b_neg, w_div0, w_ovf, w_take;
  logic [XLEN-1:0] w_a_abs, w_b_abs, w_rem_nx, w_quot_nx, w_quot_fix, w_rem_fix;
  logic [XLEN:0]   w_shifted;

  assign w_signed_op = ~bus.funct3_i[0];
  assign w_a_neg     = w_signed_op & bus.dividend_i[XLEN-1];
  assign w_b_neg     = w_signed_op & bus.divisor_i[XLEN-1];
  assign w_a_abs     = w_a_neg ? neg2c(bus.dividend_i) : bus.dividend_i;
  assign w_b_abs     = w_b_neg ? neg2c(bus.divisor_i)  : bus.divisor_i;
  assign w_div0      = (bus.divisor_i == '0);
  assign w_ovf       = w_signed_op && (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                       && (bus.divisor_i == '1);

  // Shifted partial remainder needs one extra bit: it can reach 2*divisor-1.
  assign w_shifted  = {rem_q, quot_q[XLEN-1]};
  assign w_take     = (w_shifted >= {1'b0, dvsr_q});
  assign w_rem_nx   = w_take ? (w_shifted[XLEN-1:0] - dvsr_q) : w_shifted[XLEN-1:0];
  assign w_quot_nx  = {quot_q[XLEN-2:0], w_take};
  assign w_quot_fix = (neg_a_q ^ neg_b_q) ? neg2c(w_quot_nx) : w_quot_nx;
  assign w_rem_fix  = neg_a_q ? neg2c(w_rem_nx) : w_rem_nx;

  always_comb begin
    state_d  = state_q;
    op_rem_d = op_rem_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dvsr_d   = dvsr_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_lat_d = rd_lat_q;
    rd_out_d = rd_out_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i && !bus.hold_flag_i) begin
          op_rem_d = bus.funct3_i[1];
          neg_a_d  = w_a_neg;
          neg_b_d  = w_b_neg;
          dvsr_d   = w_b_abs;
          rem_d    = '0;
          quot_d   = w_a_abs;
          cnt_d    = '0;
          rd_lat_d = bus.rd_i;
          if (w_div0) begin
            result_d = bus.funct3_i[1] ? bus.dividend_i : '1;
            rd_out_d = bus.rd_i;
            state_d  = ST_DONE;
          end else if (w_ovf) begin
            // Most-negative / -1: quotient equals the dividend, remainder zero.
            result_d = bus.funct3_i[1] ? '0 : bus.dividend_i;
            rd_out_d = bus.rd_i;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d  = w_rem_nx;
        quot_d = w_quot_nx;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) begin
          result_d = op_rem_q ? w_rem_fix : w_quot_fix;
          rd_out_d = rd_lat_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (bus.hold_flag_i) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_rem_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_lat_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      op_rem_q <= op_rem_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dvsr_q   <= dvsr_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_lat_q <= rd_lat_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign bus.busy_o     = (state_q != ST_IDLE);
  assign bus.done_o     = (state_q == ST_DONE);
  assign bus.rd_wr_en_o = (state_q == ST_DONE);
  assign bus.result_o   = result_q;
  assign bus.rd_o       = rd_out_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_div.sv
// ============================================================================
// tb_ex_div : directed vector table plus flush / reset sequences for ex_div
// Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_ex_div;
  import ex_div_pkg::*;

  localparam int LIM = 60;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ex_div_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

  ex_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op and wait for done_o; lat = 1 means done seen right after the start edge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic [4:0] rdo, output logic wr);
    bus.start_i    = 1'b1;
    bus.funct3_i   = f;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.rd_i       = rd;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    lat = 1;
    while (!bus.done_o && lat < LIM) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result_o;
    rdo = bus.rd_o;
    wr  = bus.rd_wr_en_o;
  endtask

  vec_t        vecs[17];
  int          lat;
  logic [31:0] res;
  logic [4:0]  rdo;
  logic        wr;
  logic        seen_done;

  initial begin
    vecs[0]  = '{F3_DIVU, 32'd100,        32'd7,          5'd1,  32'd14,         33};
    vecs[1]  = '{F3_REMU, 32'd100,        32'd7,          5'd2,  32'd2,          33};
    vecs[2]  = '{F3_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  33};
    vecs[3]  = '{F3_REM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  33};
    vecs[4]  = '{F3_REM,  32'd7,          32'hFFFF_FFFE,  5'd5,  32'd1,          33};
    vecs[5]  = '{F3_DIV,  32'd7,          32'hFFFF_FFFE,  5'd6,  32'hFFFF_FFFD,  33};
    vecs[6]  = '{F3_DIV,  32'h1234,       32'd0,          5'd7,  32'hFFFF_FFFF,  1};
    vecs[7]  = '{F3_REMU, 32'h1234,       32'd0,          5'd8,  32'h1234,       1};
    vecs[8]  = '{F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000,  1};
    vecs[9]  = '{F3_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0,          1};
    vecs[10] = '{F3_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          33};
    vecs[11] = '{F3_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  33};
    vecs[12] = '{F3_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd13, 32'hFFFF_FFFF,  33};
    vecs[13] = '{F3_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  5'd14, 32'd1,          33};
    vecs[14] = '{F3_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd15, 32'd14,         33};
    vecs[15] = '{F3_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd16, 32'hFFFF_FFFE,  33};
    vecs[16] = '{F3_DIVU, 32'd0,          32'd5,          5'd31, 32'd0,          33};

    total = 0;
    bad   = 0;
    bus.start_i     = 1'b0;
    bus.funct3_i    = 3'b000;
    bus.dividend_i  = '0;
    bus.divisor_i   = '0;
    bus.rd_i        = '0;
    bus.hold_flag_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy_o),     32'd0);
    chk("rst_done",   32'(bus.done_o),     32'd0);
    chk("rst_wr",     32'(bus.rd_wr_en_o), 32'd0);
    chk("rst_result", bus.result_o,        32'd0);
    chk("rst_rd",     32'(bus.rd_o),       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, lat, res, rdo, wr);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_result", i),  res,      vecs[i].exp_res);
      chk($sformatf("v%0d_rd", i),      32'(rdo), 32'(vecs[i].rd));
      chk($sformatf("v%0d_wr_en", i),   32'(wr),  32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_one_cycle", i), 32'(bus.done_o), 32'd0);
      chk($sformatf("v%0d_busy_after", i),     32'(bus.busy_o), 32'd0);
      chk($sformatf("v%0d_result_hold", i),    bus.result_o,    vecs[i].exp_res);
    end

    // Flush at cycle 10 of CALC: back to IDLE with no write and the old result kept.
    bus.start_i = 1'b1; bus.funct3_i = F3_DIVU;
    bus.dividend_i = 32'd100; bus.divisor_i = 32'd7; bus.rd_i = 5'd20;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c < 10; c++) begin
      seen_done |= bus.done_o;
      @(posedge clk); #1;
    end
    chk("hold_busy_before", 32'(bus.busy_o), 32'd1);
    bus.hold_flag_i = 1'b1;
    @(posedge clk); #1;
    bus.hold_flag_i = 1'b0;
    seen_done |= bus.done_o;
    chk("hold_busy_after",  32'(bus.busy_o), 32'd0);
    chk("hold_no_done",     32'(seen_done),  32'd0);
    chk("hold_result_kept", bus.result_o,    32'd0);
    chk("hold_rd_kept",     32'(bus.rd_o),   32'd31);
    repeat (2) @(posedge clk);
    #1;
    run_op(F3_DIVU, 32'd9, 32'd3, 5'd21, lat, res, rdo, wr);
    chk("post_hold_latency", 32'(lat), 32'd33);
    chk("post_hold_result",  res,      32'd3);
    chk("post_hold_rd",      32'(rdo), 32'd21);
    @(posedge clk); #1;

    // start_i held high through CALC with new operands must not restart the op.
    bus.start_i = 1'b1; bus.funct3_i = F3_DIVU;
    bus.dividend_i = 32'd100; bus.divisor_i = 32'd7; bus.rd_i = 5'd22;
    @(posedge clk); #1;
    bus.funct3_i = F3_REMU; bus.dividend_i = 32'd50; bus.divisor_i = 32'd3; bus.rd_i = 5'd23;
    lat = 1;
    while (!bus.done_o && lat < LIM) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.start_i = 1'b0;
    chk("ign_start_latency", 32'(lat),           32'd33);
    chk("ign_start_result",  bus.result_o,       32'd14);
    chk("ign_start_rd",      32'(bus.rd_o),      32'd22);
    @(posedge clk); #1;
    chk("ign_start_idle",    32'(bus.busy_o),    32'd0);

    // Asynchronous reset at cycle 20 of CALC, start_i high meanwhile.
    bus.start_i = 1'b1; bus.funct3_i = F3_REMU;
    bus.dividend_i = 32'd100; bus.divisor_i = 32'd7; bus.rd_i = 5'd24;
    @(posedge clk); #1;
    for (int c = 1; c < 20; c++) begin
      @(posedge clk); #1;
    end
    chk("arst_busy_before", 32'(bus.busy_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy",   32'(bus.busy_o),     32'd0);
    chk("arst_done",   32'(bus.done_o),     32'd0);
    chk("arst_wr",     32'(bus.rd_wr_en_o), 32'd0);
    chk("arst_result", bus.result_o,        32'd0);
    chk("arst_rd",     32'(bus.rd_o),       32'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(F3_REMU, 32'd100, 32'd7, 5'd25, lat, res, rdo, wr);
    chk("post_rst_latency", 32'(lat), 32'd33);
    chk("post_rst_result",  res,      32'd2);
    chk("post_rst_rd",      32'(rdo), 32'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
